cycle_display_scan: RTL
=======================

# cycle_display_scan

Parametrised multiplexed hex display driver with a built-in run-gated cycle counter, for board bring-up of the CPU. It time-multiplexes `DIGITS` common-select 7-segment digits showing one of `CH` data channels, selected by a front-panel button. Channel 0 is the internal cycle counter; channels 1..CH-1 are debug words from the core (PC, result, register taps). It replaces the fixed-width single-word counter/display pairing in the CPU top.

## Interface
Parameters:
- `DIGITS`, 8: number of scanned digits, 1..16.
- `CH`, 4: number of channels, 2..8. Channel 0 is internal.
- `DW`, 32: channel and counter width, 4..64.
- `SCAN_DIV`, 1024: clocks per digit slot, ≥2.

Ports:
- `clk`, in, 1: the single clock.
- `rst`, in, 1: asynchronous, active-low reset.
- `run`, in, 1: cycle counter enable, e.g. the not-halted flag.
- `ch_next`, in, 1: debounced level from the button; each rising edge advances the channel.
- `ch_data`, in, (CH-1)*DW: external channels; channel k is `ch_data[k*DW-1 -: DW]`.
- `cycle_cnt`, out, DW: internal counter, which is channel 0.
- `cur_ch`, out, $clog2(CH): currently selected channel.
- `seg`, out, 8: active-low segments, `{dp,g,f,e,d,c,b,a}`.
- `seg_sel`, out, DIGITS: active-low one-hot digit select. Bit 0 is the least-significant digit.

## Operation
- **Cycle counter:** increments by 1 per clock while `run=1`, holds while `run=0`, and wraps modulo 2^DW.
- **Channel select:** `ch_next_q` registers `ch_next`. A rising edge (`ch_next & ~ch_next_q`) sets `cur_ch <= (cur_ch==CH-1) ? 0 : cur_ch+1`. A held level counts as one edge.
- **Scan counters:**
  - `div` counts 0..SCAN_DIV-1.
  - When `div==SCAN_DIV-1`, `div` returns to 0 and `dig` (0..DIGITS-1) advances, wrapping to 0.
- **Snapshot:**
  - `snap` (DW) loads the selected channel's value when `div==SCAN_DIV-1 && dig==DIGITS-1`, i.e. at each frame boundary.
  - Display content is therefore coherent per frame.
  - A channel change becomes visible at the next frame.
  - For channel 0, `snap` takes `cycle_cnt` before that edge's increment.
- **Digit content:**
  - Digit i shows nibble `snap[4i+3:4i]`.
  - Digits with 4i ≥ DW show 0.
- **Hex decode:** standard a–g patterns, active-low. Examples of `seg[6:0]`: 0→0x40, 5→0x12, 7→0x78, 8→0x00, A→0x08.
- **Decimal point:** lit (`seg[7]=0`) only on the digit whose index equals `cur_ch`, as a channel indicator.
- **Output registers:** `seg` and `seg_sel` are registered from `dig` and `snap`. `seg_sel = ~(1<<dig)`.

## Timing
- **Reset values:**
  - `seg`=0xFF, `seg_sel`=all ones, `cycle_cnt`=0, `cur_ch`=0.
  - Internal: `div`=0, `dig`=0, `snap`=0, `ch_next_q`=1, so a button held through reset does not advance the channel.
- **Reset assertion:** asynchronous. Outputs take reset values immediately, with no clock, including mid-frame.
- **First clock after release:** `seg_sel`=~1 and `seg` shows "0" with dp lit (cur_ch=0 → digit 0), i.e. `seg`=0x40.
- **Output latency:** 1 clock from a `dig` or `snap` change to `seg`/`seg_sel`.
- **Frame length:** DIGITS*SCAN_DIV clocks.
- **Channel change:** `cur_ch` updates 1 clock after the `ch_next` rising edge. The dp moves on the next output update. The data follows at the next frame boundary.
- **Boundary cases:**
  - A `ch_next` edge coinciding with a frame boundary snapshots the old channel; the new channel appears next frame.
  - The counter's wrap from all-ones to 0 is not special-cased.

## Configuration
- **`SEG_LEADING_ZERO_BLANK_EN` defined:** zero digits above the most-significant nonzero nibble of `snap` are blanked (`seg[6:0]`=0x7F).
  - dp still obeys the `cur_ch` rule.
  - Digit 0 is never blanked.
  - Inner zeros are shown.
- **Macro undefined:** all digits are always shown. There is no blanking logic.

## Test plan
Bench parameters: DIGITS=8, CH=4, DW=32, SCAN_DIV=4; frame = 32 clocks.
- **Async reset:** pulse `rst` low mid-frame with the clock stopped → `seg`=0xFF, `seg_sel`=0xFF, `cycle_cnt`=0, `cur_ch`=0 immediately.
- **Counter gating:** `run=1` for 100 clocks, then `run=0` for 50 → `cycle_cnt`=100 and holds. With DW=8 and 300 run clocks → `cycle_cnt`=44 (wrap).
- **Channel display:** channel 1 = 0x12345678; raise `ch_next` once → `cur_ch`=1. After the next frame, digit 0 `seg`=0x80 and digit 1 `seg`=0x78 (dp lit).
- **Channel wrap and held level:** hold `ch_next` high 10 clocks → one advance. Four separate edges → `cur_ch` back to 0. `ch_next` high through reset release → `cur_ch` stays 0.
- **Blanking:** channel 2 = 0x00000A05, cur_ch=2, macro defined.
  - Digit 0 `seg`=0x92, digit 1 = 0xC0, digit 2 = 0x08 (dp lit), digits 3–7 = 0xFF.
  - Without the macro, digits 3–7 = 0xC0.

Source files
------------

// File: rtl/cycle_display_scan.sv
// Multiplexed hex display driver with a run-gated cycle counter as channel 0.
// Optional leading-zero blanking is enabled by defining SEG_LEADING_ZERO_BLANK_EN.
module cycle_display_scan #(
  parameter int DIGITS   = 8,
  parameter int CH       = 4,
  parameter int DW       = 32,
  parameter int SCAN_DIV = 1024
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   run,
  input  logic                   ch_next,
  input  logic [(CH-1)*DW-1:0]   ch_data,
  output logic [DW-1:0]          cycle_cnt,
  output logic [$clog2(CH)-1:0]  cur_ch,
  output logic [7:0]             seg,
  output logic [DIGITS-1:0]      seg_sel
);

  localparam int CW    = $clog2(CH);
  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int DIG_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int EXT_W = (DW > 4*DIGITS) ? DW : 4*DIGITS;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [DIG_W-1:0] DIG_LAST = DIG_W'(DIGITS - 1);
  localparam logic [CW-1:0]    CH_LAST  = CW'(CH - 1);

  // Active-low a..g patterns, bit 0 = a.
  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h40;
      4'h1: hex7 = 7'h79;
      4'h2: hex7 = 7'h24;
      4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19;
      4'h5: hex7 = 7'h12;
      4'h6: hex7 = 7'h02;
      4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00;
      4'h9: hex7 = 7'h10;
      4'hA: hex7 = 7'h08;
      4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h46;
      4'hD: hex7 = 7'h21;
      4'hE: hex7 = 7'h06;
      default: hex7 = 7'h0E;
    endcase
  endfunction

  logic              ch_next_q;
  logic [DIV_W-1:0]  div;
  logic [DIG_W-1:0]  dig;
  logic [DW-1:0]     snap;
  logic [DW-1:0]     sel_val;
  logic              div_last;
  logic              frame_end;
  logic              ch_rise;
  logic [EXT_W-1:0]  snap_ext;
  logic [3:0]        nibs [DIGITS];
  logic [3:0]        nib;
  logic              dp_on;
  logic [7:0]        seg_d;
  logic [DIGITS-1:0] seg_sel_d;

  assign div_last  = (div == DIV_LAST);
  assign frame_end = div_last && (dig == DIG_LAST);
  assign ch_rise   = ch_next & ~ch_next_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cycle_cnt <= '0;
    end else if (run) begin
      cycle_cnt <= cycle_cnt + DW'(1);
    end
  end

  // ch_next_q resets high so a button held through reset is not seen as an edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ch_next_q <= 1'b1;
      cur_ch    <= '0;
    end else begin
      ch_next_q <= ch_next;
      if (ch_rise) begin
        cur_ch <= (cur_ch == CH_LAST) ? '0 : cur_ch + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div <= '0;
      dig <= '0;
    end else if (div_last) begin
      div <= '0;
      dig <= (dig == DIG_LAST) ? '0 : dig + DIG_W'(1);
    end else begin
      div <= div + DIV_W'(1);
    end
  end

  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    sel_val = cycle_cnt;
    for (int k = 1; k < CH; k++) begin
      if (cur_ch == CW'(k)) sel_val = ch_data[k*DW-1 -: DW];
    end
  end

  // Snapshot once per frame so all digits show the same value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      snap <= '0;
    end else if (frame_end) begin
      snap <= sel_val;
    end
  end

  // Digits past the top of snap read as zero.
  assign snap_ext = EXT_W'(snap);

  always_comb begin
    for (int i = 0; i < DIGITS; i++) begin
      nibs[i] = snap_ext[4*i +: 4];
    end
  end

  assign nib       = nibs[dig];
  assign dp_on     = (32'(dig) == 32'(cur_ch));
  assign seg_sel_d = ~(DIGITS'(1) << dig);

`ifdef SEG_LEADING_ZERO_BLANK_EN
  logic [DIG_W-1:0] msd;
  logic             blank;

  // Index of the most-significant nonzero nibble; digit 0 is never blanked.
  always_comb begin
    msd = '0;
    for (int i = 1; i < DIGITS; i++) begin
      if (nibs[i] != 4'h0) msd = DIG_W'(i);
    end
  end

  assign blank = (dig > msd);

  always_comb begin
    seg_d = {~dp_on, hex7(nib)};
    if (blank) seg_d[6:0] = 7'h7F;
  end
`else
  always_comb begin
    seg_d = {~dp_on, hex7(nib)};
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      seg     <= 8'hFF;
      seg_sel <= '1;
    end else begin
      seg     <= seg_d;
      seg_sel <= seg_sel_d;
    end
  end

endmodule
